gelu_tile_sequencer: RTL and testbench

- Sequences a tile of activation rows through the 32-lane GELU array.
- Reads 32-element rows from the activation buffer, presents each row to the array with a one-cycle valid, and captures array results in an internal output FIFO.
- Writes results back to the destination buffer under a ready/enable handshake.
- Because the GELU pipeline cannot stall, a credit scheme bounds in-flight rows so that no result is ever dropped.

---
 rtl/gelu_tile_sequencer.sv | 137 +++++++++++++
 tb/tb_gelu_tile_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelu_tile_sequencer.sv
// Streams a tile of activation rows through the GELU lane array and writes the results back.
// Optional stall-cycle counter is built only when GELU_SEQ_PERF_EN is defined.
module gelu_tile_sequencer #(
    parameter int NUM_LANES  = 32,
    parameter int W          = 32,
    parameter int ADDR_W     = 16,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      src_base,
    input  logic [ADDR_W-1:0]      dst_base,
    input  logic [ADDR_W-1:0]      num_rows,
    output logic                   busy,
    output logic                   done,
    output logic                   err_unexp,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [NUM_LANES*W-1:0] rd_data,
    output logic                   gelu_valid_in,
    output logic [NUM_LANES*W-1:0] gelu_xi,
    input  logic                   gelu_valid_out,
    input  logic [NUM_LANES*W-1:0] gelu_out,
    output logic                   wr_en,
    input  logic                   wr_ready,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [NUM_LANES*W-1:0] wr_data,
    output logic [31:0]            perf_stall_cycles
);
    localparam int DW = NUM_LANES * W;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t                         state;
    logic [ADDR_W-1:0]              src_q, dst_q, num_q;
    logic [ADDR_W-1:0]              issued, written;
    logic [CW-1:0]                  in_flight, fifo_cnt;
    logic [PW-1:0]                  wp, rp;
    logic [FIFO_DEPTH-1:0][DW-1:0]  fifo_mem;
    logic [RD_LAT:1]                vld_pipe;

    logic active, credit_ok, push, pop;

    // Every issued row owns a FIFO slot until written back, so the
    // non-stallable array can never overrun the FIFO.
    assign active    = (state == RUN) || (state == DRAIN);
    assign credit_ok = (in_flight + fifo_cnt) < CW'(FIFO_DEPTH);
    assign push      = gelu_valid_out && active && (in_flight != '0);
    assign pop       = wr_en && wr_ready;

    assign rd_en         = (state == RUN) && (issued < num_q) && credit_ok;
    assign rd_addr       = src_q + issued;
    assign gelu_valid_in = vld_pipe[RD_LAT];
    assign gelu_xi       = rd_data;
    assign wr_en         = (fifo_cnt != '0);
    assign wr_addr       = dst_q + written;
    assign wr_data       = fifo_mem[rp];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wp] <= gelu_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_unexp <= 1'b0;
            src_q     <= '0;
            dst_q     <= '0;
            num_q     <= '0;
            issued    <= '0;
            written   <= '0;
            in_flight <= '0;
            fifo_cnt  <= '0;
            wp        <= '0;
            rp        <= '0;
            vld_pipe  <= '0;
        end else begin
            done        <= 1'b0;
            vld_pipe[1] <= rd_en;
            for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];

            in_flight <= in_flight + CW'(rd_en) - CW'(push);
            fifo_cnt  <= fifo_cnt + CW'(push) - CW'(pop);
            if (gelu_valid_out && active && (in_flight == '0)) err_unexp <= 1'b1;
            if (rd_en) issued <= issued + 1'b1;
            if (push)  wp <= wp + 1'b1;
            if (pop) begin
                rp      <= rp + 1'b1;
                written <= written + 1'b1;
            end

            case (state)
                IDLE: if (start) begin
                    src_q   <= src_base;
                    dst_q   <= dst_base;
                    num_q   <= num_rows;
                    issued  <= '0;
                    written <= '0;
                    busy    <= 1'b1;
                    state   <= (num_rows == '0) ? FIN : RUN;
                end
                RUN:   if (issued == num_q)  state <= DRAIN;
                DRAIN: if (written == num_q) state <= FIN;
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GELU_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            perf_q <= '0;
        else if (state == IDLE && start)
            perf_q <= '0;
        else if (state == RUN && issued < num_q && !credit_ok && perf_q != 32'hFFFF_FFFF)
            perf_q <= perf_q + 32'd1;
    end

    assign perf_stall_cycles = perf_q;
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_gelu_tile_sequencer.sv
// Randomized bench for gelu_tile_sequencer: buffer, GELU array and destination are
// modelled behaviourally and every output is compared each cycle.
module tb_gelu_tile_sequencer;
    localparam int NL = 32, W = 32, AW = 16, RD_LAT = 2, FD = 4, DW = NL * W;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [AW-1:0] src_base = '0, dst_base = '0, num_rows = '0;
    logic          busy, done, err_unexp, rd_en, gelu_valid_in, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data = '0, gelu_xi, gelu_out = '0, wr_data;
    logic          gelu_valid_out = 1'b0, wr_ready = 1'b0;
    logic [31:0]   perf_stall_cycles;

    gelu_tile_sequencer #(.NUM_LANES(NL), .W(W), .ADDR_W(AW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
        .num_rows(num_rows), .busy(busy), .done(done), .err_unexp(err_unexp), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .gelu_valid_in(gelu_valid_in), .gelu_xi(gelu_xi),
        .gelu_valid_out(gelu_valid_out), .gelu_out(gelu_out), .wr_en(wr_en), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .perf_stall_cycles(perf_stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 64;
    bit chk_en = 0, rst_req = 0, start_req = 0, inject = 0;
    logic [AW-1:0] s_src, s_dst;
    int s_num;

    // tile-level model: counts of rows read, returned by the array and written back
    bit tile_on = 0, err_exp = 0;
    logic [AW-1:0] m_src = '0, m_dst = '0;
    int m_num = 0, m_iss = 0, m_wr = 0, m_ret = 0, perf_m = 0, done_due = -1;
    int lat = 5, rdy_pct = 100, hold_until = 0;
    int done_cnt = 0, last_done_cyc = 0, start_cyc = 0;
    logic [AW-1:0] rd_log[$], wr_log[$];

    bit            rv[64];
    logic [AW-1:0] ra[64];
    bit            gv[64];
    logic [DW-1:0] gx[64];

    function automatic logic [DW-1:0] mem_row(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*W +: W] = {a, 16'(i * 257)} ^ 32'h3C5A_96E1;
        return r;
    endfunction

    function automatic logic [DW-1:0] gelu_ref(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*W +: W] = x[i*W +: W] * 32'd3 + 32'(i);
        return r;
    endfunction

    function automatic logic [DW-1:0] junk();
        logic [DW-1:0] r;
        for (int i = 0; i < NL; i++) r[i*W +: W] = $urandom();
        return r;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got[63:0]=%0h expected[63:0]=%0h", name, cyc, act[63:0], exp[63:0]);
        end
    endtask

    task automatic model_reset();
        tile_on = 0; err_exp = 0; done_due = -1;
        m_iss = 0; m_wr = 0; m_ret = 0; perf_m = 0; m_num = 0; m_src = '0; m_dst = '0;
        foreach (rv[i]) rv[i] = 0;
    endtask

    task automatic step();
        bit rd_exp, wr_exp, in_fin;
        int iss_prev, infl, ip, ig;
        logic [31:0] perf_exp;
        @(negedge clk);
        cyc++;
        in_fin = (done_due == cyc + 1);
        rd_exp = tile_on && (m_iss < m_num) && ((m_iss - m_wr) < FD);
        wr_exp = (m_ret - m_wr) > 0;
`ifdef GELU_SEQ_PERF_EN
        perf_exp = 32'(perf_m);
`else
        perf_exp = 32'd0;
`endif
        if (chk_en) begin
            chk("rd_en", rd_en, rd_exp);
            chk("wr_en", wr_en, wr_exp);
            chk("busy", busy, tile_on);
            chk("done", done, cyc == done_due);
            chk("err_unexp", err_unexp, err_exp);
            chk("perf_stall_cycles", perf_stall_cycles, perf_exp);
            if (rd_en) chk("rd_addr", rd_addr, AW'(m_src + AW'(m_iss)));
            if (wr_en) begin
                chk("wr_addr", wr_addr, AW'(m_dst + AW'(m_wr)));
                chk("wr_data", wr_data, gelu_ref(mem_row(AW'(m_src + AW'(m_wr)))));
            end
        end
        if (done) begin done_cnt++; last_done_cyc = cyc; end
        if (rd_en) rd_log.push_back(rd_addr);
        iss_prev = m_iss;
        if (tile_on && m_iss < m_num && (m_iss - m_wr) >= FD) perf_m++;
        if (rd_en) m_iss++;
        rv[cyc % 64] = rd_en;
        ra[cyc % 64] = rd_addr;

        rst_n    = !rst_req;
        wr_ready = (cyc < hold_until) ? 1'b0 : ($urandom_range(99) < rdy_pct);
        ip       = (cyc - RD_LAT) % 64;
        rd_data  = rv[ip] ? mem_row(ra[ip]) : junk();
        ig       = (cyc - lat) % 64;
        gelu_valid_out = gv[ig] | inject;
        gelu_out = inject ? junk() : gelu_ref(gx[ig]);
        start    = start_req;
        src_base = s_src; dst_base = s_dst; num_rows = AW'(s_num);

        #1;
        if (chk_en) begin
            chk("gelu_valid_in", gelu_valid_in, rv[ip]);
            if (gelu_valid_in) chk("gelu_xi", gelu_xi, mem_row(ra[ip]));
        end
        gv[cyc % 64] = gelu_valid_in;
        gx[cyc % 64] = gelu_xi;

        if (rst_req) model_reset();
        else begin
            if (wr_en && wr_ready) begin
                wr_log.push_back(wr_addr);
                m_wr++;
                if (tile_on && m_wr == m_num) done_due = cyc + 3;
            end
            infl = iss_prev - m_ret;
            if (gelu_valid_out && tile_on && !in_fin) begin
                if (infl > 0) m_ret++;
                else err_exp = 1;
            end
            if (start && !tile_on) begin
                tile_on = 1; m_src = s_src; m_dst = s_dst; m_num = s_num;
                m_iss = 0; m_wr = 0; m_ret = 0; perf_m = 0; start_cyc = cyc;
                if (s_num == 0) done_due = cyc + 2;
            end else if (cyc + 1 == done_due) tile_on = 0;
        end
    endtask

    task automatic do_reset();
        rst_req = 1; step(); rst_req = 0; step();
    endtask

    task automatic launch(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n, input int hold);
        rd_log.delete(); wr_log.delete();
        s_src = s; s_dst = d; s_num = n; start_req = 1;
        hold_until = cyc + 2 + hold;
        step();
        start_req = 0;
    endtask

    task automatic finish_tile(input int budget);
        int t = 0;
        while (tile_on && t < budget) begin step(); t++; end
        if (tile_on) begin
            n_chk++; n_fail++;
            $display("FAIL tile_timeout: still busy after %0d cycles", budget);
            do_reset();
        end
        step();
    endtask

    initial begin
        int d0, t;
        chk_en = 0; rst_req = 1; step(); chk_en = 1; rst_req = 0; step();
        chk("reset_rd_addr", rd_addr, 16'h0000);
        chk("reset_wr_addr", wr_addr, 16'h0000);

        // basic tile, plus a start pulse while busy that must be ignored
        d0 = done_cnt;
        launch(16'h0100, 16'h0200, 8, 0);
        repeat (3) step();
        s_src = 16'h9999; s_dst = 16'h8888; s_num = 3; start_req = 1; step(); start_req = 0;
        finish_tile(300);
        chk("t1_reads", rd_log.size(), 8);
        chk("t1_first_rd", rd_log[0], 16'h0100);
        chk("t1_last_rd", rd_log[7], 16'h0107);
        chk("t1_writes", wr_log.size(), 8);
        chk("t1_first_wr", wr_log[0], 16'h0200);
        chk("t1_last_wr", wr_log[7], 16'h0207);
        chk("t1_done_once", done_cnt - d0, 1);
        step();
        chk("t1_idle_busy", busy, 0);

        // empty tile
        launch(16'h0300, 16'h0400, 0, 0);
        finish_tile(50);
        chk("t2_reads", rd_log.size(), 0);
        chk("t2_writes", wr_log.size(), 0);
        chk("t2_done_latency", last_done_cyc - start_cyc, 2);

        // write backpressure for 30 cycles
        launch(16'h0100, 16'h0200, 8, 30);
        repeat (29) step();
        chk("t3_reads_stalled", rd_log.size(), 4);
        finish_tile(300);
        chk("t3_writes", wr_log.size(), 8);
        chk("t3_last_wr", wr_log[7], 16'h0207);
`ifdef GELU_SEQ_PERF_EN
        chk("t3_perf_nonzero", perf_stall_cycles != 0, 1);
`else
        chk("t3_perf_tied", perf_stall_cycles, 0);
`endif

        // address wrap
        launch(16'hFFFE, 16'h0010, 4, 0);
        finish_tile(200);
        chk("t4_rd0", rd_log[0], 16'hFFFE);
        chk("t4_rd1", rd_log[1], 16'hFFFF);
        chk("t4_rd2", rd_log[2], 16'h0000);
        chk("t4_rd3", rd_log[3], 16'h0001);

        // unexpected array result with nothing in flight
        launch(16'h0020, 16'h0030, 4, 0);
        inject = 1; step(); inject = 0;
        finish_tile(200);
        chk("t5_err_sticky", err_unexp, 1);
        do_reset();
        chk("t5_err_cleared", err_unexp, 0);

        // reset mid-tile after three writes; array residue then lands in IDLE
        launch(16'h0500, 16'h0600, 8, 0);
        t = 0;
        while (wr_log.size() < 3 && t < 200) begin step(); t++; end
        chk("t6_three_writes", wr_log.size() >= 3, 1);
        d0 = done_cnt;
        do_reset();
        chk("t6_rst_rd_addr", rd_addr, 16'h0000);
        chk("t6_rst_wr_addr", wr_addr, 16'h0000);
        chk("t6_rst_busy", busy, 0);
        repeat (20) step();
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_residue_ignored", err_unexp, 0);
        d0 = done_cnt;
        launch(16'h0700, 16'h0800, 2, 0);
        finish_tile(200);
        chk("t6_new_writes", wr_log.size(), 2);
        chk("t6_new_done", done_cnt - d0, 1);

        // randomized tiles
        for (int k = 0; k < 8; k++) begin
            lat     = $urandom_range(10, 1);
            rdy_pct = $urandom_range(100, 30);
            repeat (12) step();
            launch(AW'($urandom()), AW'($urandom()), $urandom_range(12, 1), $urandom_range(8, 0));
            finish_tile(3000);
            chk("rand_writes", wr_log.size(), m_num);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
